// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter sharing one ALU between two requesters; one operation in flight, results returned on RES.
// Latency REQ->RES_VLDn is 3 cycles with a 1-cycle ALU; optional WAIT watchdog under ALU_ARB_TIMEOUT_EN.
module alu_arb #(
  parameter int WIDTH   = 8,
  parameter int TMO_CYC = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ0,
  input  logic               REQ1,
  input  logic [3:0]         FUN0,
  input  logic [3:0]         FUN1,
  input  logic [WIDTH-1:0]   A0,
  input  logic [WIDTH-1:0]   B0,
  input  logic [WIDTH-1:0]   A1,
  input  logic [WIDTH-1:0]   B1,
  output logic               ALU_EN,
  output logic [3:0]         ALU_FUN,
  output logic [WIDTH-1:0]   ALU_A,
  output logic [WIDTH-1:0]   ALU_B,
  input  logic [2*WIDTH-1:0] ALU_OUT,
  input  logic               ALU_VLD,
  output logic [2*WIDTH-1:0] RES,
  output logic               RES_VLD0,
  output logic               RES_VLD1,
  output logic               BUSY,
  output logic               ERR
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state, state_n;
  logic               gnt, gnt_n;
  logic               last, last_n;
  logic               pick;
  logic               alu_en_n, busy_n, vld0_n, vld1_n;
  logic [3:0]         fun_n;
  logic [WIDTH-1:0]   a_n, b_n;
  logic [2*WIDTH-1:0] res_n;

  if (TMO_CYC < 1) begin : g_tmo_chk
    $error("TMO_CYC must be at least 1");
  end

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TMO_CYC + 1);
  logic [WD_W-1:0] wd, wd_n;
  logic            err_n;
  logic            tmo;
  assign tmo = (wd == WD_W'(TMO_CYC - 1));
`else
  assign ERR = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    last_n   = last;
    pick     = 1'b0;
    alu_en_n = 1'b0;
    vld0_n   = 1'b0;
    vld1_n   = 1'b0;
    fun_n    = ALU_FUN;
    a_n      = ALU_A;
    b_n      = ALU_B;
    res_n    = RES;
`ifdef ALU_ARB_TIMEOUT_EN
    wd_n     = wd;
    err_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (REQ0 | REQ1) begin
          // on a tie the requester not served last wins
          pick     = (REQ0 & REQ1) ? ~last : REQ1;
          gnt_n    = pick;
          fun_n    = pick ? FUN1 : FUN0;
          a_n      = pick ? A1 : A0;
          b_n      = pick ? B1 : B0;
          alu_en_n = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        state_n = WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
        wd_n    = '0;
`endif
      end
      WAIT: begin
        if (ALU_VLD) begin
          res_n   = ALU_OUT;
          vld0_n  = ~gnt;
          vld1_n  = gnt;
          state_n = DONE;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (tmo) begin
          res_n   = '1;
          err_n   = 1'b1;
          vld0_n  = ~gnt;
          vld1_n  = gnt;
          state_n = DONE;
        end else begin
          wd_n = wd + 1'b1;
        end
`endif
      end
      DONE: begin
        last_n  = gnt;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last     <= 1'b1;
      ALU_EN   <= 1'b0;
      ALU_FUN  <= '0;
      ALU_A    <= '0;
      ALU_B    <= '0;
      RES      <= '0;
      RES_VLD0 <= 1'b0;
      RES_VLD1 <= 1'b0;
      BUSY     <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      wd       <= '0;
      ERR      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      last     <= last_n;
      ALU_EN   <= alu_en_n;
      ALU_FUN  <= fun_n;
      ALU_A    <= a_n;
      ALU_B    <= b_n;
      RES      <= res_n;
      RES_VLD0 <= vld0_n;
      RES_VLD1 <= vld1_n;
      BUSY     <= busy_n;
`ifdef ALU_ARB_TIMEOUT_EN
      wd       <= wd_n;
      ERR      <= err_n;
`endif
    end
  end

endmodule
